hex_ascii_serializer: RTL
=========================

Name: hex_ascii_serializer

Overview:
Converts a DATA_W-bit binary word into a stream of ASCII hex characters, most significant nibble first, one character per output handshake. It sits between status/counter sources and the UART transmit byte interface. This is the successor to the single-nibble combinational converter, generalised in word width, letter case and leading-zero handling, and using valid/ready flow control on both sides.

Parameters:
DATA_W, 16, input word width in bits; must be a multiple of 4 and at least 4. NIB = DATA_W/4 nibbles.
UPPERCASE, 1, 1: digits 10-15 map to 'A'-'F' (0x41-0x46). 0: they map to 'a'-'f' (0x61-0x66).
SUPPRESS_LZ, 0, 1: skip leading zero nibbles, but always emit at least one character.

Ports:
clk  in  1  system clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input word available.
in_ready  out  1  block can accept a word; high only in IDLE.
in_data  in  DATA_W  word to convert; sampled when in_valid && in_ready.
out_valid  out  1  out_char is valid.
out_ready  in  1  downstream (UART TX) accepts the character.
out_char  out  8  ASCII character.
busy  out  1  high while not in IDLE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_char=0x00, busy=0. Reset aborts any word in progress; no further characters are emitted after reset.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_data into word_q and set nibble index idx.
    - SUPPRESS_LZ=0: idx=NIB-1.
    - SUPPRESS_LZ=1: idx is the index of the highest non-zero nibble, or 0 if the word is 0.
    - Next state: SEND.
  - SEND: out_valid=1; out_char=ascii(word_q[idx]).
    - On out_ready with idx>0: idx decrements.
    - On out_ready with idx==0: go to CR if HEX_SERIALIZER_CRLF_EN is defined, else IDLE.
  - CR: out_char=0x0D; advance to LF on out_ready.
  - LF: out_char=0x0A; advance to IDLE on out_ready.
- Latency: the first character is valid on the cycle after input acceptance. A character is transferred on every cycle where out_valid && out_ready.
- Output registers: out_valid and out_char are registered.
  - While out_valid && !out_ready, out_char and out_valid hold stable.
  - out_valid never drops without a handshake, except on rst.
- Throughput:
  - in_ready is low for the whole word.
  - The IDLE cycle after the last character is mandatory; there is no back-to-back acceptance.
  - Word period is at least chars+1 cycles.
- Mapping: nibble 0-9 maps to 0x30-0x39; 10-15 map per UPPERCASE. There are no other outputs.
- Width: idx is clog2(NIB) bits, minimum 1. NIB=1 is legal and emits exactly one character.
- Changes on in_data while not accepted are ignored.

Optional Feature:
HEX_SERIALIZER_CRLF_EN
- Defined: after the last hex character, emit 0x0D then 0x0A, each with its own handshake. Characters per word = digits+2.
- Undefined: the CR and LF states do not exist, and the word ends after the last hex digit.

Decomposition:
- Package hex_ascii_pkg holds:
  - state enum {IDLE, SEND, CR, LF}
  - constants ASCII_0=0x30, ASCII_UA=0x41, ASCII_LA=0x61, ASCII_CR=0x0D, ASCII_LF=0x0A
  - function nibble_to_ascii(nibble, uppercase)
  - function msb_nonzero_nibble(word), used for the leading-zero scan
- No sub-module; a single FSM plus datapath.

Test Plan:
- DATA_W=16, in 0x1A2F, out_ready=1 -> chars 0x31,0x41,0x32,0x46 on 4 consecutive cycles starting the cycle after accept; then in_ready=1.
- Same word, out_ready toggling 1-0-0-1 -> each char holds stable while stalled; the sequence is unchanged and there are no duplicates.
- SUPPRESS_LZ=1:
  - 0x000B -> single 0x42.
  - 0x0000 -> single 0x30.
  - 0x0100 -> 0x31,0x30,0x30.
- UPPERCASE=0, DATA_W=8, 0xAB -> 0x61,0x62.
- HEX_SERIALIZER_CRLF_EN defined, DATA_W=8, 0x05 -> 0x30,0x35,0x0D,0x0A.
- rst asserted after the 2nd char of 0x1A2F -> next cycle out_valid=0, in_ready=1; the next word 0xFFFF emits 0x46 x4 cleanly.

Source files
------------

// File: rtl/hex_ascii_pkg.sv
// Shared types, ASCII constants and helpers for the hex ASCII serializer.
package hex_ascii_pkg;

  typedef enum logic [1:0] {IDLE, SEND, CR, LF} state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Widest word the leading-zero scan handles; narrower words are zero-extended.
  localparam int MAX_W = 64;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble,
                                                 input logic       uppercase);
    if (nibble < 4'd10) return ASCII_0 + {4'd0, nibble};
    return (uppercase ? ASCII_UA : ASCII_LA) + {4'd0, nibble} - 8'd10;
  endfunction

  // Index of the highest non-zero nibble, 0 for an all-zero word.
  function automatic int unsigned msb_nonzero_nibble(input logic [MAX_W-1:0] word);
    int unsigned msb = 0;
    for (int i = 0; i < MAX_W / 4; i++) begin
      if (word[i*4 +: 4] != 4'd0) msb = i;
    end
    return msb;
  endfunction

endpackage

// File: rtl/hex_ascii_serializer.sv
// Binary word to ASCII hex character stream, MS nibble first, valid/ready on both sides.
// Optional macro HEX_SERIALIZER_CRLF_EN appends CR LF after the last digit of each word.
module hex_ascii_serializer #(
  parameter int DATA_W      = 16,
  parameter bit UPPERCASE   = 1'b1,
  parameter bit SUPPRESS_LZ = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              busy
);
  import hex_ascii_pkg::*;

  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d, start_idx;
  logic               out_valid_d;
  logic [7:0]         out_char_d;

  function automatic logic [3:0] nibble_at(input logic [DATA_W-1:0] w,
                                           input logic [IDX_W-1:0]  i);
    return 4'(w >> {i, 2'b00});
  endfunction

  assign start_idx = SUPPRESS_LZ ? IDX_W'(msb_nonzero_nibble(MAX_W'(in_data)))
                                 : IDX_W'(NIB - 1);

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  // Next character is computed here so out_char is a clean register output.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    out_valid_d = out_valid;
    out_char_d  = out_char;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d      = in_data;
          idx_d       = start_idx;
          state_d     = SEND;
          out_valid_d = 1'b1;
          out_char_d  = nibble_to_ascii(nibble_at(in_data, start_idx), UPPERCASE);
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q != '0) begin
            idx_d      = idx_q - IDX_W'(1);
            out_char_d = nibble_to_ascii(nibble_at(word_q, idx_q - IDX_W'(1)), UPPERCASE);
          end else begin
`ifdef HEX_SERIALIZER_CRLF_EN
            state_d     = CR;
            out_char_d  = ASCII_CR;
`else
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_char_d  = 8'h00;
`endif
          end
        end
      end
`ifdef HEX_SERIALIZER_CRLF_EN
      CR: begin
        if (out_ready) begin
          state_d    = LF;
          out_char_d = ASCII_LF;
        end
      end
      LF: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_char_d  = 8'h00;
        end
      end
`endif
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_char_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      out_valid <= out_valid_d;
      out_char  <= out_char_d;
    end
  end

endmodule
